// File: rtl/seg7_scan_display_pkg.sv
// Shared definitions for 7-segment displays: segment bit order and hex glyph table.
package seg7_scan_display_pkg;

    // Segment vector bit order, MSB first: {g,f,e,d,c,b,a}. Bit 0 is segment a.
    typedef struct packed {
        logic g;
        logic f;
        logic e;
        logic d;
        logic c;
        logic b;
        logic a;
    } seg7_t;

    // Active-high glyphs for 0..F; entry [n] is the glyph for nibble n.
    localparam logic [15:0][6:0] SEG7_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_scan_display_if.sv
// Port bundle between the output register file (master) and the scan display (slave).
// Inputs are plain level signals with no handshake: the display samples them only at
// frame snapshots, so the master may change them on any cycle.
interface seg7_scan_display_if;
    logic [31:0] value_in;
    logic [7:0]  dp_in;
    logic        blank_lz;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    modport master (
        output value_in, dp_in, blank_lz,
        input  an, seg, dp, frame_tick
    );

    modport slave (
        input  value_in, dp_in, blank_lz,
        output an, seg, dp, frame_tick
    );
endinterface

// File: rtl/seg7_scan_display_hex_to_seg7.sv
// Combinational nibble-to-glyph decoder, active-high segments.
module hex_to_seg7
    import seg7_scan_display_pkg::*;
(
    input  logic [3:0] nib_i,
    output seg7_t      seg_o
);
    assign seg_o = SEG7_LUT[nib_i];
endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed 8-digit hex display. The shown value is snapshotted only at
// frame boundaries so a store landing mid-scan never produces a torn display.
module seg7_scan_display
    import seg7_scan_display_pkg::*;
#(
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYCLES   = 16,
    parameter int NUM_DIGITS     = 8,
    parameter int ACTIVE_LOW_SEG = 1,
    parameter int ACTIVE_LOW_AN  = 1
) (
    input logic                 io_clk,
    input logic                 reset,
    seg7_scan_display_if.slave  bus
);
    localparam int             PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0]  BLANK_END  = PW'(BLANK_CYCLES);
    localparam logic [2:0]     DIGIT_LAST = 3'(NUM_DIGITS - 1);
    // Nibbles at or above NUM_DIGITS are ignored when looking for leading zeros.
    localparam logic [31:0]    DIGIT_MASK = (NUM_DIGITS >= 8) ? 32'hFFFF_FFFF
                                          : 32'((64'd1 << (4 * NUM_DIGITS)) - 64'd1);
    localparam logic [7:0]     AN_INV     = (ACTIVE_LOW_AN != 0)  ? 8'hFF : 8'h00;
    localparam logic [6:0]     SEG_INV    = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
    localparam logic           DP_INV     = (ACTIVE_LOW_SEG != 0);

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    digit_q, digit_d;
    logic [31:0]   shadow_value_q;
    logic [7:0]    shadow_dp_q;
    logic          shadow_blz_q;
    logic          load_pending_q;
    logic          frame_tick_q;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          presc_wrap;
    logic          end_of_frame;
    logic          load;
    logic [3:0]    nib;
    logic [31:0]   upper_nibbles;
    logic          digit_blank;
    logic          in_blank_window;
    seg7_t         glyph;

    hex_to_seg7 u_dec (
        .nib_i (nib),
        .seg_o (glyph)
    );

    // Scan position, snapshot trigger and the pin values for the current slot.
    always_comb begin
        presc_wrap      = (presc_q == PRESC_LAST);
        end_of_frame    = presc_wrap && (digit_q == DIGIT_LAST);
        load            = load_pending_q || end_of_frame;

        presc_d         = presc_wrap ? '0 : presc_q + 1'b1;
        digit_d         = digit_q;
        if (presc_wrap) begin
            digit_d     = (digit_q == DIGIT_LAST) ? 3'd0 : digit_q + 3'd1;
        end

        nib             = shadow_value_q[{digit_q, 2'b00} +: 4];
        // A digit is a leading zero when it and every more-significant digit are zero.
        upper_nibbles   = (shadow_value_q & DIGIT_MASK) >> {digit_q, 2'b00};
        digit_blank     = shadow_blz_q && (digit_q != 3'd0) && (upper_nibbles == 32'd0);
        in_blank_window = (presc_q < BLANK_END);

        an_d            = AN_INV;
        if (!in_blank_window && !digit_blank) begin
            an_d        = (8'h01 << digit_q) ^ AN_INV;
        end
        seg_d           = glyph ^ SEG_INV;
        dp_d            = (shadow_dp_q[digit_q] && !digit_blank) ^ DP_INV;
    end

    // Scan counters and snapshot registers.
    always_ff @(posedge io_clk) begin
        if (reset) begin
            presc_q        <= '0;
            digit_q        <= 3'd0;
            shadow_value_q <= 32'd0;
            shadow_dp_q    <= 8'd0;
            shadow_blz_q   <= 1'b0;
            load_pending_q <= 1'b1;
            frame_tick_q   <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            digit_q        <= digit_d;
            frame_tick_q   <= load;
            if (load) begin
                shadow_value_q <= bus.value_in;
                shadow_dp_q    <= bus.dp_in;
                shadow_blz_q   <= bus.blank_lz;
                load_pending_q <= 1'b0;
            end
        end
    end

    // Registered pin drivers, reset to the inactive level.
    always_ff @(posedge io_clk) begin
        if (reset) begin
            an_q  <= AN_INV;
            seg_q <= SEG_INV;
            dp_q  <= DP_INV;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with CLK_DIV=4, BLANK_CYCLES=1, active-low pins.
module tb_seg7_scan_display;
    logic io_clk = 1'b0;
    logic reset  = 1'b1;
    int   checks = 0;
    int   passed = 0;

    seg7_scan_display_if bus ();

    seg7_scan_display #(
        .CLK_DIV        (4),
        .BLANK_CYCLES   (1),
        .NUM_DIGITS     (8),
        .ACTIVE_LOW_SEG (1),
        .ACTIVE_LOW_AN  (1)
    ) dut (
        .io_clk (io_clk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 io_clk = ~io_clk;

    // Active-high glyphs, written out independently of the design package.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;  4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;  4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;  4'hE: glyph = 7'h79;  default: glyph = 7'h71;
        endcase
    endfunction

    // One clock, then sample 1 time unit after the edge.
    task automatic step();
        @(posedge io_clk);
        #1;
    endtask

    // Reset for one cycle with the given inputs already applied; samples land after the reset edge.
    task automatic apply_reset(input logic [31:0] v, input logic [7:0] d, input logic b);
        bus.value_in = v;
        bus.dp_in    = d;
        bus.blank_lz = b;
        reset        = 1'b1;
        step();
        reset        = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(32'h12345678, 8'h00, 1'b0);
        checks++; if (bus.an !== 8'hFF) $display("FAIL reset_an got %h want ff", bus.an); else passed++;
        checks++; if (bus.seg !== 7'h7F) $display("FAIL reset_seg got %h want 7f", bus.seg); else passed++;
        checks++; if (bus.dp !== 1'b1) $display("FAIL reset_dp got %b want 1", bus.dp); else passed++;
        checks++; if (bus.frame_tick !== 1'b0) $display("FAIL reset_tick got %b want 0", bus.frame_tick); else passed++;
    endtask

    // First frame after reset: snapshot at cycle 0, digits 0..7 in 4-cycle slots.
    task automatic test_scan();
        logic [31:0] v;
        logic [7:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_ft;
        int          slot;
        int          p;
        v = 32'h12345678;
        apply_reset(v, 8'h00, 1'b0);
        for (int c = 0; c < 32; c++) begin
            step();
            slot  = c / 4;
            p     = c % 4;
            e_an  = (p == 0) ? 8'hFF : ~(8'h01 << slot);
            // Cycle 0 still decodes the cleared shadow.
            e_seg = (c == 0) ? ~glyph(4'h0) : ~glyph(v[4*slot +: 4]);
            e_ft  = (c == 0) || (c == 31);
            checks++; if (bus.an !== e_an) $display("FAIL scan_an c=%0d got %h want %h", c, bus.an, e_an); else passed++;
            checks++; if (bus.seg !== e_seg) $display("FAIL scan_seg c=%0d got %h want %h", c, bus.seg, e_seg); else passed++;
            checks++; if (bus.dp !== 1'b1) $display("FAIL scan_dp c=%0d got %b want 1", c, bus.dp); else passed++;
            checks++; if (bus.frame_tick !== e_ft) $display("FAIL scan_tick c=%0d got %b want %b", c, bus.frame_tick, e_ft); else passed++;
        end
    endtask

    // The first sampled cycle of every slot has all anodes off; the rest have exactly one on.
    task automatic test_anti_ghost();
        logic [7:0] e_an;
        int         slot;
        apply_reset(32'h9ABCDEF0, 8'h00, 1'b0);
        for (int c = 0; c < 64; c++) begin
            step();
            slot = (c / 4) % 8;
            e_an = ((c % 4) == 0) ? 8'hFF : ~(8'h01 << slot);
            checks++; if (bus.an !== e_an) $display("FAIL ghost_an c=%0d got %h want %h", c, bus.an, e_an); else passed++;
        end
    endtask

    // A store during slot 3 stays invisible until the next frame snapshot.
    task automatic test_mid_frame();
        logic [31:0] v;
        logic [6:0]  e_seg;
        logic        e_ft;
        int          slot;
        v = 32'h12345678;
        apply_reset(v, 8'h00, 1'b0);
        for (int c = 0; c < 64; c++) begin
            step();
            if (c == 13) bus.value_in = 32'hFFFFFFFF;
            slot = (c / 4) % 8;
            e_ft = (c == 0) || (c == 31) || (c == 63);
            if (c >= 1) begin
                e_seg = (c < 32) ? ~glyph(v[4*slot +: 4]) : ~glyph(4'hF);
                checks++; if (bus.seg !== e_seg) $display("FAIL mid_seg c=%0d got %h want %h", c, bus.seg, e_seg); else passed++;
            end
            checks++; if (bus.frame_tick !== e_ft) $display("FAIL mid_tick c=%0d got %b want %b", c, bus.frame_tick, e_ft); else passed++;
        end
    endtask

    // 0xA0 with blanking: digits 0 and 1 lit with points, digits 2..7 dark with no point.
    task automatic test_leading_zero();
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        int         slot;
        int         p;
        apply_reset(32'h000000A0, 8'hFF, 1'b1);
        for (int c = 0; c < 32; c++) begin
            step();
            slot = c / 4;
            p    = c % 4;
            e_an = (p == 0 || slot >= 2) ? 8'hFF : ~(8'h01 << slot);
            e_dp = (c == 0 || slot >= 2);
            checks++; if (bus.an !== e_an) $display("FAIL lz_an c=%0d got %h want %h", c, bus.an, e_an); else passed++;
            checks++; if (bus.dp !== e_dp) $display("FAIL lz_dp c=%0d got %b want %b", c, bus.dp, e_dp); else passed++;
            if (slot < 2 && p != 0) begin
                e_seg = (slot == 0) ? ~glyph(4'h0) : ~glyph(4'hA);
                checks++; if (bus.seg !== e_seg) $display("FAIL lz_seg c=%0d got %h want %h", c, bus.seg, e_seg); else passed++;
            end
        end
    endtask

    // Value 0 with blanking: only digit 0 lights, showing "0".
    task automatic test_zero();
        logic [7:0] e_an;
        int         p;
        apply_reset(32'h00000000, 8'h00, 1'b1);
        for (int c = 0; c < 32; c++) begin
            step();
            p    = c % 4;
            e_an = (c >= 1 && c <= 3) ? 8'hFE : 8'hFF;
            checks++; if (bus.an !== e_an) $display("FAIL zero_an c=%0d got %h want %h", c, bus.an, e_an); else passed++;
            if (c < 4 && p != 0) begin
                checks++; if (bus.seg !== 7'h40) $display("FAIL zero_seg c=%0d got %h want 40", c, bus.seg); else passed++;
            end
        end
    endtask

    // One-cycle reset in slot 5 idles the pins, then scanning restarts with a fresh snapshot.
    task automatic test_reset_mid();
        logic [7:0] e_an;
        logic [6:0] e_seg;
        int         slot;
        int         p;
        apply_reset(32'h12345678, 8'h00, 1'b0);
        for (int c = 0; c < 22; c++) step();
        bus.value_in = 32'hABCD0123;
        apply_reset(32'hABCD0123, 8'h00, 1'b0);
        checks++; if (bus.an !== 8'hFF) $display("FAIL rmid_an got %h want ff", bus.an); else passed++;
        checks++; if (bus.seg !== 7'h7F) $display("FAIL rmid_seg got %h want 7f", bus.seg); else passed++;
        checks++; if (bus.dp !== 1'b1) $display("FAIL rmid_dp got %b want 1", bus.dp); else passed++;
        checks++; if (bus.frame_tick !== 1'b0) $display("FAIL rmid_tick got %b want 0", bus.frame_tick); else passed++;
        for (int c = 0; c < 8; c++) begin
            step();
            slot  = c / 4;
            p     = c % 4;
            e_an  = (p == 0) ? 8'hFF : ~(8'h01 << slot);
            e_seg = (c == 0) ? 7'h40 : ((slot == 0) ? 7'h30 : 7'h24);
            checks++; if (bus.an !== e_an) $display("FAIL rmid_scan_an c=%0d got %h want %h", c, bus.an, e_an); else passed++;
            checks++; if (bus.seg !== e_seg) $display("FAIL rmid_scan_seg c=%0d got %h want %h", c, bus.seg, e_seg); else passed++;
            checks++; if (bus.frame_tick !== (c == 0)) $display("FAIL rmid_scan_tick c=%0d got %b want %b", c, bus.frame_tick, (c == 0)); else passed++;
        end
    endtask

    initial begin
        bus.value_in = 32'd0;
        bus.dp_in    = 8'd0;
        bus.blank_lz = 1'b0;
        test_reset();
        test_scan();
        test_anti_ghost();
        test_mid_frame();
        test_leading_zero();
        test_zero();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Downstream consumer of the CPU's memory-mapped output port registers.
- Takes one 32-bit port value and shows it as 8 hex digits on a time-multiplexed 7-segment display, one digit at a time.
- Frames the value so a CPU store mid-scan never produces a torn display: the value is snapshotted only at frame boundaries.
- Sits between the I/O output register file and the board pins.

Parameters:
- CLK_DIV, 50000, io_clk cycles per digit slot (>= 2).
- BLANK_CYCLES, 16, anode-off cycles at start of each slot for anti-ghosting (< CLK_DIV).
- NUM_DIGITS, 8, digits scanned (1..8); nibble i drives digit i.
- ACTIVE_LOW_SEG, 1, invert seg/dp at the pins when 1.
- ACTIVE_LOW_AN, 1, invert anodes at the pins when 1.

Ports:
- io_clk  input  1  system clock; all state on posedge.
- reset  input  1  synchronous, active-high.
- value_in  input  32  value to display (nibble 0 = rightmost digit).
- dp_in  input  8  decimal-point enable per digit.
- blank_lz  input  1  leading-zero blanking enable.
- an  output  8  digit enables (after ACTIVE_LOW_AN).
- seg  output  7  segments {g,f,e,d,c,b,a} (after ACTIVE_LOW_SEG).
- dp  output  1  decimal point (after ACTIVE_LOW_SEG).
- frame_tick  output  1  one-cycle pulse on each snapshot.

Behaviour:
- The interface uses one clock, io_clk. Reset is synchronous and active-high.
- Reset state:
  - Prescaler = 0, digit_idx = 0, shadow value/dp/blank_lz = 0, load_pending = 1.
  - All outputs at their inactive pin level: an all off, seg all off, dp off, frame_tick = 0.
- Prescaler: counts 0..CLK_DIV-1 and wraps. On wrap, digit_idx increments modulo NUM_DIGITS.
- end_of_frame = (prescaler == CLK_DIV-1) && (digit_idx == NUM_DIGITS-1).
- Snapshot:
  - Shadow regs load value_in, dp_in and blank_lz on the cycle load_pending == 1, or on any end_of_frame cycle.
  - load_pending clears on that load.
  - frame_tick is registered and is 1 in the cycle after each load.
- Inputs may change on any cycle. Only the value sampled at a snapshot is ever displayed. Value changes between snapshots are invisible.
- Digit decode:
  - nib = shadow[4*digit_idx +: 4].
  - Active-high patterns for 0..F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
- Leading-zero blanking: digit i (i > 0) is blank when shadow blank_lz == 1 and nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never blanked, so value 0 shows a single "0".
- Blank digit: its anode stays off for the whole slot. Its dp is also suppressed.
- Anti-ghosting: while prescaler < BLANK_CYCLES, all anodes are off. seg/dp may already show the new digit during this window.
- Output registers:
  - an/seg/dp are registered from the current prescaler/digit_idx/shadow, so there is 1 cycle of latency.
  - Exactly one anode is active outside the blank window, at bit digit_idx. Anodes at bits >= NUM_DIGITS are always off.
- Reset mid-frame: next cycle returns to the reset state. The following cycle re-snapshots via load_pending.

Decomposition:
- Shared package/include holds the 16-entry 7-segment pattern constant and the SEG bit-order definition.
- One natural sub-module: hex_to_seg7, a combinational nibble-to-pattern decoder that the team reuses for other displays.
- Scan counter, snapshot logic and output registers stay in this block.

Test Plan:
All cases use CLK_DIV=4, BLANK_CYCLES=1, NUM_DIGITS=8, active-low pins.
- Reset then value_in=0x12345678, blank_lz=0:
  - Snapshot in cycle 1 and frame_tick pulses.
  - Slot 0 cycles 1..3 show an=FE, seg=~7F (digit 8).
  - Slot 1 shows an=FD, seg=~07.
  - Full frame = 32 cycles.
- Anti-ghost check: first registered cycle of every slot has an=FF.
- Mid-frame change:
  - value_in goes to 0xFFFFFFFF during slot 3; digits 3..7 still show the old nibbles.
  - From the next frame (after frame_tick) all digits show seg=~71.
- value_in=0x000000A0, blank_lz=1, dp_in=0xFF:
  - Digits 0..1 are lit as 0 and A.
  - Digits 2..7 keep an=FF for their whole slots and dp never asserts for them.
- value_in=0, blank_lz=1: only digit 0 lights, showing seg=~3F. All other slots have an=FF.
- Assert reset for 1 cycle mid-slot 5:
  - Next cycle all outputs are inactive.
  - Scan restarts at digit 0 with a fresh snapshot and frame_tick pulse.
